fetch_issue_unit: RTL and testbench

- Front end of the CPU. Holds the program counter and fetches instruction words `{opcode, K}` from instruction memory.
- Presents each opcode and its immediate K to the control unit for exactly one issue cycle.
- Consumes the control unit's LP (load PC) to redirect the PC to K.
- Outside issue cycles it drives the bubble opcode, which the control decoder treats as a no-op (its default branch).

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/pc_counter.sv | 26 ++
 rtl/fetch_issue_unit.sv | 77 +++++++
 tb/tb_fetch_issue_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: widths, special opcodes, fetch FSM states.
// No logic here; combinational helpers only.
// Not applicable (no flow control in a package).
package cpu_pkg;

  localparam int PC_W = 4;
  localparam int OP_W = 7;
  localparam int K_W  = 8;

  // Bubble decodes to no asserted control lines; HALT stops fetch until reset.
  localparam logic [OP_W-1:0] BUBBLE_OP = 7'h7F;
  localparam logic [OP_W-1:0] HALT_OP   = 7'h7E;

  // Opcodes shared with the control unit.
  localparam logic [OP_W-1:0] MOV_A_K = 7'h02;
  localparam logic [OP_W-1:0] ADD_A_K = 7'h06;
  localparam logic [OP_W-1:0] INC_B   = 7'h24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  // Instruction word layout as returned by instruction memory.
  typedef struct packed {
    logic [OP_W-1:0] opcode;
    logic [K_W-1:0]  k;
  } instr_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter register with load and wrapping increment.
// Latency: new value visible one cycle after load/inc.
// Backpressure: none; holds value when neither load nor inc is set.
module pc_counter
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  // Load takes priority; increment wraps naturally at 2^PC_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_issue_unit.sv
// CPU front end: fetches {opcode,K} at pc and issues it to the control unit for one cycle.
// Latency: min 2 cycles/instruction (REQ with same-cycle valid, then ISSUE); +1 per imem wait cycle.
// Backpressure: imem_req held until imem_valid; a started fetch always completes regardless of run_en.
module fetch_issue_unit
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run_en,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_valid,
  input  logic [OP_W+K_W-1:0] imem_rdata,
  output logic [OP_W-1:0]     opcode,
  output logic [K_W-1:0]      k_out,
  output logic                issue,
  input  logic                lp,
  output logic [PC_W-1:0]     pc,
  output logic                halted,
  output logic [15:0]         instr_count
);

  fetch_state_t state;
  instr_t       ir;
  instr_t       fetched;

  assign fetched = instr_t'(imem_rdata);

  // Outputs decode straight from state and ir so the control unit sees the
  // opcode in the same cycle issue rises.
  assign issue     = (state == ISSUE);
  assign halted    = (state == HALTED);
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign opcode    = issue ? ir.opcode : BUBBLE_OP;
  assign k_out     = issue ? ir.k : '0;

  pc_counter u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (issue & lp),
    .inc      (issue & ~lp),
    .load_val (ir.k[PC_W-1:0]),
    .pc       (pc)
  );

  // Fetch/issue FSM; also captures the instruction word and counts issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ir          <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run_en) state <= REQ;
        end
        REQ: begin
          if (imem_valid) begin
            ir    <= fetched;
            // HALT is captured but never issued.
            state <= (fetched.opcode == HALT_OP) ? HALTED : ISSUE;
          end
        end
        ISSUE: begin
          if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
          state <= run_en ? REQ : IDLE;
        end
        HALTED: begin
          state <= HALTED;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Directed self-checking bench for fetch_issue_unit.
// Inputs driven 1 time unit after the rising edge; outputs checked there too.
// Each imem response is supplied by the bench.
module tb_fetch_issue_unit;
  import cpu_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                run_en;
  logic                imem_req;
  logic [PC_W-1:0]     imem_addr;
  logic                imem_valid;
  logic [OP_W+K_W-1:0] imem_rdata;
  logic [OP_W-1:0]     opcode;
  logic [K_W-1:0]      k_out;
  logic                issue;
  logic                lp;
  logic [PC_W-1:0]     pc;
  logic                halted;
  logic [15:0]         instr_count;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_issue_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_en      (run_en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .opcode      (opcode),
    .k_out       (k_out),
    .issue       (issue),
    .lp          (lp),
    .pc          (pc),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks all idle outputs (no request, no issue, bubble on the opcode bus).
  task automatic check_idle(input string tag);
    check({tag, ".req"},    imem_req, 0);
    check({tag, ".issue"},  issue, 0);
    check({tag, ".opcode"}, opcode, 32'h7F);
    check({tag, ".k"},      k_out, 0);
  endtask

  initial begin
    rst_n = 1'b0; run_en = 1'b0; imem_valid = 1'b0; imem_rdata = '0; lp = 1'b0;

    // Reset state
    #3;
    check_idle("rst");
    check("rst.halted", halted, 0);
    check("rst.pc", pc, 0);
    check("rst.cnt", instr_count, 0);
    #9;
    rst_n = 1'b1;

    // Zero-latency fetch of {02,05}
    run_en = 1'b1;
    step();
    check("t1.req", imem_req, 1);
    check("t1.addr", imem_addr, 0);
    check("t1.opc_req", opcode, 32'h7F);
    imem_valid = 1'b1; imem_rdata = {MOV_A_K, 8'h05};
    step();
    imem_valid = 1'b0; run_en = 1'b0;
    check("t1.issue", issue, 1);
    check("t1.opcode", opcode, 32'h02);
    check("t1.k", k_out, 32'h05);
    check("t1.pc_in_issue", pc, 0);
    step();
    check_idle("t1.after");
    check("t1.pc", pc, 1);
    check("t1.cnt", instr_count, 1);

    // Fetch with 3 extra wait cycles; run_en dropped mid-fetch is ignored
    run_en = 1'b1;
    step();
    run_en = 1'b0;
    lp = 1'b1; // lp outside ISSUE must not move pc
    for (int i = 0; i < 4; i++) begin
      check("t2.req", imem_req, 1);
      check("t2.addr", imem_addr, 1);
      check("t2.opcode", opcode, 32'h7F);
      check("t2.issue", issue, 0);
      if (i == 3) begin
        imem_valid = 1'b1; imem_rdata = {ADD_A_K, 8'h11};
        lp = 1'b0;
      end
      step();
    end
    imem_valid = 1'b0;
    check("t2.issue_pulse", issue, 1);
    check("t2.opcode_iss", opcode, 32'h06);
    check("t2.k_iss", k_out, 32'h11);
    step();
    check("t2.issue_end", issue, 0);
    check("t2.pc", pc, 2);
    check("t2.cnt", instr_count, 2);

    // Idle after run_en dropped in ISSUE: no requests
    step();
    check_idle("t3.idle1");
    step();
    check_idle("t3.idle2");
    run_en = 1'b1;
    step();
    check("t3.resume_req", imem_req, 1);
    check("t3.resume_addr", imem_addr, 2);

    // Jump with lp=1, K=3A -> pc=A (K truncated)
    imem_valid = 1'b1; imem_rdata = {MOV_A_K, 8'h3A};
    step();
    imem_valid = 1'b0; lp = 1'b1;
    check("t4.issue", issue, 1);
    check("t4.k", k_out, 32'h3A);
    step();
    lp = 1'b0;
    check("t4.pc_jump", pc, 32'hA);
    check("t4.req_back2back", imem_req, 1);
    check("t4.addr", imem_addr, 32'hA);

    // Jump to 15 via K=3F, then unknown opcode 55 at pc=15 with lp=0 wraps to 0
    imem_valid = 1'b1; imem_rdata = {INC_B, 8'h3F};
    step();
    imem_valid = 1'b0; lp = 1'b1;
    check("t5.opcode", opcode, 32'h24);
    step();
    lp = 1'b0;
    check("t5.pc15", pc, 32'hF);
    imem_valid = 1'b1; imem_rdata = {7'h55, 8'hC3};
    step();
    imem_valid = 1'b0;
    check("t5.unk_issue", issue, 1);
    check("t5.unk_opcode", opcode, 32'h55);
    check("t5.unk_k", k_out, 32'hC3);
    step();
    check("t5.pc_wrap", pc, 0);
    check("t5.cnt", instr_count, 5);

    // HALT word at pc=0
    check("t6.req", imem_req, 1);
    imem_valid = 1'b1; imem_rdata = {HALT_OP, 8'h09};
    step();
    imem_valid = 1'b0;
    check("t6.halted", halted, 1);
    check_idle("t6.h");
    check("t6.pc", pc, 0);
    check("t6.cnt", instr_count, 5);
    for (int i = 0; i < 4; i++) begin
      run_en = i[0];
      step();
      check("t6.stay_halted", halted, 1);
      check("t6.stay_req", imem_req, 0);
      check("t6.stay_issue", issue, 0);
    end

    // Reset clears HALTED; fetch one instruction then reset mid-REQ
    rst_n = 1'b0;
    #1;
    check("t7.halt_clr", halted, 0);
    rst_n = 1'b1;
    run_en = 1'b1;
    step();
    check("t7.req0", imem_req, 1);
    imem_valid = 1'b1; imem_rdata = {INC_B, 8'h00};
    step();
    imem_valid = 1'b0;
    check("t7.issue", issue, 1);
    step();
    check("t7.pc1", pc, 1);
    check("t7.cnt1", instr_count, 1);
    check("t7.req1", imem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7.async_req", imem_req, 0);
    check("t7.async_pc", pc, 0);
    check("t7.async_cnt", instr_count, 0);
    check("t7.async_opcode", opcode, 32'h7F);
    check("t7.async_halted", halted, 0);
    step();
    check("t7.held_req", imem_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
